// File: rtl/pipe_ctrl.sv
// Pipeline controller for the five-stage RV32I core: stall/bubble steering and PC redirect sequencing.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_stall_req,
    input  logic              id_stall_req,
    input  logic              mem_stall_req,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    output logic [4:0]        stall_o,
    output logic [4:0]        bubble_o,
    output logic              branch_interception_o,
    output logic              pc_redirect_o,
    output logic [ADDR_W-1:0] pc_redirect_addr_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cycles_o,
    output logic [31:0]       perf_stalls_o,
    output logic [31:0]       perf_flushes_o
`endif
);

    // state | meaning
    // RUN   | normal flow; a taken branch redirects here or parks in PEND
    // PEND  | redirect target latched, waiting for fetch to go ready
    // FLUSH | redirect issued, draining wrong-path fetches for cnt_q cycles
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    // A frozen pipeline or a memory stall holds every piece of sequencing state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        if (rdy && !mem_stall_req) begin
            case (state_q)
                ST_PEND: begin
                    if (!if_stall_req) begin
                        state_d = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end
                end
                ST_FLUSH: begin
                    if (!if_stall_req) begin
                        cnt_d = cnt_q - 2'd1;
                        if (cnt_q <= 2'd1) begin
                            state_d = ST_RUN;
                            cnt_d   = 2'd0;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    if (ex_branch_taken) begin
                        if (if_stall_req) begin
                            state_d = ST_PEND;
                            tgt_d   = ex_branch_target;
                        end else begin
                            state_d = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
                            cnt_d   = FLUSH_INIT;
                        end
                    end
                end
            endcase
        end
    end

    // Interception is dropped during a memory stall: nothing advances, and the
    // wrong-path instruction stays parked in IF/ID until PEND/FLUSH resumes.
    always_comb begin
        stall_o               = 5'b00000;
        bubble_o              = 5'b00000;
        branch_interception_o = 1'b0;
        pc_redirect_o         = 1'b0;
        pc_redirect_addr_o    = '0;
        if (rst || !rdy) begin
            stall_o = 5'b11111;
        end else if (mem_stall_req) begin
            stall_o  = 5'b01111;
            bubble_o = 5'b10000;
        end else begin
            case (state_q)
                ST_PEND: begin
                    branch_interception_o = 1'b1;
                    stall_o               = 5'b00001;
                    bubble_o              = 5'b00010;
                    if (!if_stall_req) begin
                        pc_redirect_o      = 1'b1;
                        pc_redirect_addr_o = tgt_q;
                    end
                end
                ST_FLUSH: begin
                    branch_interception_o = 1'b1;
                    bubble_o              = 5'b00010;
                    stall_o               = {4'b0000, if_stall_req};
                end
                default: begin
                    if (ex_branch_taken) begin
                        branch_interception_o = 1'b1;
                        bubble_o              = 5'b00110;
                        if (!if_stall_req) begin
                            pc_redirect_o      = 1'b1;
                            pc_redirect_addr_o = ex_branch_target;
                        end
                    end else if (id_stall_req) begin
                        stall_o  = 5'b00011;
                        bubble_o = 5'b00100;
                    end else if (if_stall_req) begin
                        stall_o  = 5'b00001;
                        bubble_o = 5'b00010;
                    end
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic [31:0] perf_flushes_q, perf_flushes_d;

    always_comb begin
        perf_cycles_d  = perf_cycles_q;
        perf_stalls_d  = perf_stalls_q;
        perf_flushes_d = perf_flushes_q;
        if (rdy) begin
            perf_cycles_d  = perf_cycles_q + 32'd1;
            perf_stalls_d  = perf_stalls_q + {31'd0, stall_o[0]};
            perf_flushes_d = perf_flushes_q + {31'd0, pc_redirect_o};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q  <= 32'd0;
            perf_stalls_q  <= 32'd0;
            perf_flushes_q <= 32'd0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_stalls_q  <= perf_stalls_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_cycles_o  = perf_cycles_q;
    assign perf_stalls_o  = perf_stalls_q;
    assign perf_flushes_o = perf_flushes_q;
`endif

endmodule
